// File: rtl/exec_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// exec_muldiv_unit_if
// Execute-stage handshake between the E-stage datapath / hazard unit and the
// RV32M multiply/divide unit.
//   valid_i   E holds an M-extension op
//   funct3_i  M-extension function select
//   rs1_i     forwarded operand A (sampled on accept only)
//   rs2_i     forwarded operand B (sampled on accept only)
//   flush_i   hazard flush_e, aborts any op in flight
//   stall_o   hold F/D/E (combinational)
//   done_o    1-cycle pulse, result_o valid
//   result_o  result, held until the next completion
// Modports: master = E-stage side, slave = multiply/divide unit.
// ----------------------------------------------------------------------------
interface exec_muldiv_unit_if;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/exec_muldiv_unit.sv
// ----------------------------------------------------------------------------
// exec_muldiv_unit
// Iterative RV32M multiply/divide unit beside the ALU in the execute stage.
// Shift-add multiply and restoring radix-2 divide on operand magnitudes,
// one iteration per cycle, sign applied when the result is formed.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   exec_muldiv_unit_if.slave (valid/funct3/rs1/rs2/flush in,
//         stall/done/result out)
// Parameters:
//   XLEN       operand width, only 32 is supported
//   EARLY_OUT  1: divide-by-zero and signed overflow finish in one cycle
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> MUL* ops use a registered 33x33 signed multiply (1 cycle)
//   undefined -> MUL* ops are iterative like division
// ----------------------------------------------------------------------------
module exec_muldiv_unit #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    exec_muldiv_unit_if.slave  bus
);
    localparam int unsigned W  = XLEN;
    localparam int unsigned W2 = 2 * XLEN;
    localparam int unsigned CW = 5;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  hi_q, hi_d;          // partial product high / remainder
    logic [W-1:0]  lo_q, lo_d;          // multiplier / dividend->quotient
    logic [W-1:0]  opb_q, opb_d;        // multiplicand / divisor magnitude
    logic          neg_q, neg_d;        // product / quotient negative
    logic          sa_q, sa_d;          // dividend negative (remainder sign)
    logic          spec_q, spec_d;      // special-case divide in flight
    logic [W-1:0]  spec_res_q, spec_res_d;
    logic          done_q, done_d;
    logic [W-1:0]  result_q, result_d;

    // ---------------- accept-side decode on the live operands ----------------
    logic          accept;
    logic          in_div;
    logic          a_signed, b_signed;
    logic          a_neg, b_neg;
    logic [W-1:0]  abs_a, abs_b;
    logic          div_zero, div_ovf, in_spec;
    logic [W-1:0]  in_spec_res;

    always_comb begin
        accept   = (state_q == IDLE) & bus.valid_i & ~bus.flush_i;
        in_div   = bus.funct3_i[2];
        // MUL low word is sign-independent, so it runs unsigned
        a_signed = (bus.funct3_i == F_MULH) | (bus.funct3_i == F_MULHSU) |
                   (bus.funct3_i == F_DIV)  | (bus.funct3_i == F_REM);
        b_signed = (bus.funct3_i == F_MULH) |
                   (bus.funct3_i == F_DIV)  | (bus.funct3_i == F_REM);
        a_neg    = a_signed & bus.rs1_i[W-1];
        b_neg    = b_signed & bus.rs2_i[W-1];
        abs_a    = a_neg ? (W'(0) - bus.rs1_i) : bus.rs1_i;
        abs_b    = b_neg ? (W'(0) - bus.rs2_i) : bus.rs2_i;

        div_zero = in_div & (bus.rs2_i == W'(0));
        div_ovf  = in_div & ~bus.funct3_i[0] &
                   (bus.rs1_i == {1'b1, {(W-1){1'b0}}}) &
                   (bus.rs2_i == {W{1'b1}});
        in_spec  = div_zero | div_ovf;

        // funct3[1] selects the remainder flavour among divide ops
        in_spec_res = '0;
        if (div_zero) begin
            in_spec_res = bus.funct3_i[1] ? bus.rs1_i : {W{1'b1}};
        end else if (div_ovf) begin
            in_spec_res = bus.funct3_i[1] ? W'(0) : {1'b1, {(W-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle signed 33x33 multiply; bit 32 carries operand signedness
    logic [W:0]    fast_a, fast_b;
    logic [W2-1:0] fast_prod;
    logic [W-1:0]  fast_res;

    always_comb begin
        fast_a    = {a_signed & bus.rs1_i[W-1], bus.rs1_i};
        fast_b    = {b_signed & bus.rs2_i[W-1], bus.rs2_i};
        fast_prod = W2'($signed(fast_a) * $signed(fast_b));
        fast_res  = (bus.funct3_i == F_MUL) ? fast_prod[W-1:0] : fast_prod[W2-1:W];
    end
`endif

    // ---------------- one iteration of multiply or divide ----------------
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift, div_diff;
    logic          div_ge;
    logic [W-1:0]  it_hi, it_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : (W+1)'(0));
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[W];
        if (op_q[2]) begin
            it_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            it_lo = {lo_q[W-2:0], div_ge};
        end else begin
            it_hi = mul_sum[W:1];
            it_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // ---------------- sign fix-up and result select ----------------
    logic [W2-1:0] prod, prod_s;
    logic [W-1:0]  quo_s, rem_s, fin_res;

    always_comb begin
        prod   = {it_hi, it_lo};
        prod_s = neg_q ? (W2'(0) - prod) : prod;
        quo_s  = neg_q ? (W'(0) - it_lo) : it_lo;
        rem_s  = sa_q  ? (W'(0) - it_hi) : it_hi;
        unique case (op_q)
            F_MUL:                      fin_res = prod_s[W-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fin_res = prod_s[W2-1:W];
            F_DIV, F_DIVU:              fin_res = quo_s;
            F_REM, F_REMU:              fin_res = rem_s;
            default:                    fin_res = prod_s[W-1:0];
        endcase
    end

    // ---------------- next-state / datapath control ----------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        neg_d      = neg_q;
        sa_d       = sa_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        done_d     = 1'b0;
        result_d   = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = bus.funct3_i;
                    hi_d       = '0;
                    lo_d       = in_div ? abs_a : abs_b;
                    opb_d      = in_div ? abs_b : abs_a;
                    neg_d      = a_neg ^ b_neg;
                    sa_d       = a_neg;
                    spec_d     = in_spec;
                    spec_res_d = in_spec_res;
                    count_d    = CW'(W - 1);
                    state_d    = RUN;
                    if (EARLY_OUT && in_spec) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = in_spec_res;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!in_div) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end
`endif
                end
            end
            RUN: begin
                hi_d    = it_hi;
                lo_d    = it_lo;
                count_d = count_q - CW'(1);
                if (count_q == CW'(0)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = spec_q ? spec_res_q : fin_res;
                end
            end
            DONE: begin
                // valid_i here belongs to the retiring op
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush aborts everything, suppresses completion and holds result
        if (bus.flush_i) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            neg_q      <= 1'b0;
            sa_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            neg_q      <= neg_d;
            sa_q       <= sa_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    // Hazard stall is combinational so E holds in the accept cycle itself
    assign bus.stall_o  = bus.valid_i & ~done_q & ~bus.flush_i;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_exec_muldiv_unit
// Directed vectors with hand-computed results, latencies and stall counts
// for the RV32M multiply/divide unit, including flush and reset mid-op.
// ----------------------------------------------------------------------------
module tb_exec_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    exec_muldiv_unit_if bus ();

    exec_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif
    localparam int LAT_DIV = 33;
    localparam int LAT_SPC = 1;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step();
        bus.valid_i = 1'b0;
    endtask

    // Issues one op (after `lead` cycles), waits for done_o, checks
    // latency, result, stall cycles and stall release. Ends in the done cycle.
    task automatic run_op(input string tag, input int lead, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          output int done_cyc);
        int n;
        int stalls;
        bit seen;
        n = 0;
        stalls = 0;
        seen = 1'b0;
        for (int i = 0; i < lead; i++) step();
        bus.valid_i  = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        #1;
        check({tag, "_stall_acc"}, 32'(bus.stall_o), 32'd1);
        while (!seen && n < 80) begin
            step();
            n++;
            if (n == 1) begin
                bus.rs1_i = $urandom;
                bus.rs2_i = $urandom;
                #1;
            end
            if (bus.done_o) seen = 1'b1;
            else if (bus.stall_o) stalls++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_res"}, bus.result_o, exp_res);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
        check({tag, "_stall_rel"}, 32'(bus.stall_o), 32'd0);
        done_cyc = cyc;
    endtask

    int d1, d2, dummy, pulses;

    initial begin
        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        step();
        step();
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_res", bus.result_o, 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        rst = 1'b0;

        // multiply
        run_op("mul",    1, F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL, dummy); idle();
        run_op("mulh",   1, F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL, dummy); idle();
        run_op("mulhu",  1, F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL, dummy); idle();
        run_op("mulhsu", 1, F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_MUL, dummy); idle();

        // divide
        run_op("div",    1, F_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, LAT_DIV, dummy); idle();
        run_op("rem",    1, F_REM,  32'd100,      32'hFFFFFFF9, 32'h00000002, LAT_DIV, dummy); idle();
        run_op("div_n",  1, F_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, LAT_DIV, dummy); idle();
        run_op("rem_n",  1, F_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, LAT_DIV, dummy); idle();
        run_op("divu",   1, F_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, LAT_DIV, dummy); idle();
        run_op("remu",   1, F_REMU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, LAT_DIV, dummy); idle();

        // special cases
        run_op("divu_z", 1, F_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, LAT_SPC, dummy); idle();
        run_op("remu_z", 1, F_REMU, 32'h1234,     32'd0,        32'h00001234, LAT_SPC, dummy); idle();
        run_op("div_z",  1, F_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, LAT_SPC, dummy); idle();
        run_op("rem_z",  1, F_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_SPC, dummy); idle();
        run_op("div_ov", 1, F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPC, dummy); idle();
        run_op("rem_ov", 1, F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPC, dummy); idle();

        // flush at accept+10 of a DIV, MUL issued at accept+11
        step();
        bus.valid_i  = 1'b1;
        bus.funct3_i = F_DIV;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd3;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.done_o) pulses++;
        end
        bus.flush_i = 1'b1;
        #1;
        check("flush_done", 32'(bus.done_o), 32'd0);
        check("flush_stall", 32'(bus.stall_o), 32'd0);
        step();
        bus.flush_i = 1'b0;
        check("flush_early", 32'(pulses), 32'd0);
        check("flush_done_n", 32'(bus.done_o), 32'd0);
        check("flush_held", bus.result_o, 32'h00000000);
        run_op("mul_fl", 0, F_MUL, 32'd3, 32'd5, 32'd15, LAT_MUL, dummy);
        idle();
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.done_o) pulses++;
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_res_keep", bus.result_o, 32'd15);

        // reset at accept+5 of a DIVU
        step();
        bus.valid_i  = 1'b1;
        bus.funct3_i = F_DIVU;
        bus.rs1_i    = 32'h5000;
        bus.rs2_i    = 32'd3;
        for (int k = 1; k <= 5; k++) step();
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        step();
        rst = 1'b0;
        check("rstmid_done", 32'(bus.done_o), 32'd0);
        check("rstmid_res", bus.result_o, 32'd0);
        check("rstmid_stall", 32'(bus.stall_o), 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.done_o) pulses++;
        end
        check("rstmid_no_done", 32'(pulses), 32'd0);

        // back-to-back DIVU then REMU
        run_op("b2b_divu", 1, F_DIVU, 32'd100, 32'd7, 32'd14, LAT_DIV, d1);
        run_op("b2b_remu", 1, F_REMU, 32'd100, 32'd7, 32'd2,  LAT_DIV, d2);
        check("b2b_gap", 32'(d2 - d1), 32'd34);
        idle();
        step();
        check("end_idle_done", 32'(bus.done_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
